// File: rtl/bin_coalesce_pkg.sv
// Shared types and helpers for the bin event coalescer: word layout,
// accumulator state encoding and the saturating 32-bit adder.
package bin_coalesce_pkg;

  localparam int ABITS_DEF = 7;
  localparam int DBITS_DEF = 64;
  localparam int BIN_LSB   = 32;
  localparam int SUM_MSB   = 31;
  localparam int MAX_BITS  = 128;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2
  } state_e;

  typedef struct packed {
    logic        sat;
    logic [31:0] sum;
  } sat_res_t;

  // Returns a wide word; callers truncate to their DBITS. Upper bits stay zero.
  function automatic logic [MAX_BITS-1:0] pack_word(input logic [MAX_BITS-BIN_LSB-1:0] bin,
                                                    input logic [SUM_MSB:0] sum);
    return {bin, sum};
  endfunction

  function automatic sat_res_t sat_add32(input logic [31:0] a, input logic [31:0] b);
    sat_res_t    r;
    logic [32:0] s;
    s     = {1'b0, a} + {1'b0, b};
    r.sat = s[32];
    r.sum = s[32] ? 32'hFFFF_FFFF : s[31:0];
    return r;
  endfunction

endpackage

// File: rtl/bin_event_coalescer_axis_out_reg.sv
// Single-entry registered AXI-stream output stage. out_free says a new word
// may be loaded this cycle without overwriting one the sink has not taken.
module axis_out_reg #(
  parameter int DBITS = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [DBITS-1:0] load_data,
  output logic             out_free,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic [DBITS-1:0] m_axis_tdata
);

  logic             valid_q, valid_d;
  logic [DBITS-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (m_axis_tready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_free      = !valid_q | m_axis_tready;
  assign m_axis_tvalid = valid_q;
  assign m_axis_tdata  = data_q;

endmodule

// File: rtl/bin_event_coalescer.sv
// Merges consecutive (bin, increment) events into one saturating 32-bit sum
// per run and emits {bin, sum} words; zero increments never open a run.
module bin_event_coalescer
  import bin_coalesce_pkg::*;
#(
  parameter int ABITS   = ABITS_DEF,
  parameter int DBITS   = DBITS_DEF,
  parameter int VBITS   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic [ABITS-1:0] s_bin,
  input  logic [VBITS-1:0] s_inc,
  input  logic             s_last,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic [DBITS-1:0] m_axis_tdata,
  output logic             sat_flag,
  output state_e           dbg_state
);

  localparam int CNT_W = $clog2(TIMEOUT);

  // Both ports: a beat moves on a clock where valid & ready are high; a source
  // holds valid and payload until then, and ready never depends on payload.

  state_e           state_q, state_d;
  logic [ABITS-1:0] bin_q, bin_d;
  logic [31:0]      sum_q, sum_d;
  logic [CNT_W-1:0] idle_q, idle_d;
  logic             sat_q, sat_d;

  logic             out_free;
  logic             xfer;
  logic             acc;
  logic             inc_zero;
  logic [31:0]      inc32;
  sat_res_t         add;

  assign s_axis_tready = (state_q == EMPTY) | ((state_q == ACCUM) & out_free);
  assign acc           = s_axis_tvalid & s_axis_tready;
  assign inc32         = 32'(s_inc);
  assign inc_zero      = (s_inc == '0);
  assign add           = sat_add32(sum_q, inc32);

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    sum_d   = sum_q;
    idle_d  = idle_q;
    sat_d   = sat_q;
    xfer    = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (acc && !inc_zero) begin
          bin_d   = s_bin;
          sum_d   = inc32;
          idle_d  = '0;
          state_d = s_last ? FLUSH : ACCUM;
        end
      end
      ACCUM: begin
        if (acc) begin
          // A dropped zero increment leaves idle_q alone but still honours s_last.
          if (!inc_zero) begin
            idle_d = '0;
            if (s_bin == bin_q) begin
              sum_d = add.sum;
              sat_d = sat_q | add.sat;
            end else begin
              xfer  = 1'b1;
              bin_d = s_bin;
              sum_d = inc32;
            end
          end
          if (s_last) state_d = FLUSH;
        end else if (idle_q == CNT_W'(TIMEOUT - 1)) begin
          idle_d = '0;
          if (out_free) begin
            xfer    = 1'b1;
            state_d = EMPTY;
          end else begin
            state_d = FLUSH;
          end
        end else begin
          idle_d = idle_q + CNT_W'(1);
        end
      end
      FLUSH: begin
        if (out_free) begin
          xfer    = 1'b1;
          idle_d  = '0;
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= EMPTY;
      bin_q   <= '0;
      sum_q   <= '0;
      idle_q  <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      sum_q   <= sum_d;
      idle_q  <= idle_d;
      sat_q   <= sat_d;
    end
  end

  axis_out_reg #(.DBITS(DBITS)) u_out (
    .clock         (clock),
    .reset         (reset),
    .load          (xfer),
    .load_data     (DBITS'(pack_word((MAX_BITS-BIN_LSB)'(bin_q), sum_q))),
    .out_free      (out_free),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata)
  );

  assign sat_flag  = sat_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_bin_event_coalescer.sv
// Self-checking bench for bin_event_coalescer: table-driven event runs, directed
// timing/backpressure/saturation/reset sequences and a scoreboard on the output.
module tb_bin_event_coalescer;
  import bin_coalesce_pkg::*;

  localparam int ABITS   = 7;
  localparam int DBITS   = 64;
  localparam int VBITS   = 32;
  localparam int TIMEOUT = 16;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             s_axis_tvalid = 1'b0;
  logic             s_axis_tready;
  logic [ABITS-1:0] s_bin = '0;
  logic [VBITS-1:0] s_inc = '0;
  logic             s_last = 1'b0;
  logic             m_axis_tvalid;
  logic             m_axis_tready;
  logic [DBITS-1:0] m_axis_tdata;
  logic             sat_flag;
  state_e           dbg_state;

  logic tb_ready  = 1'b1;
  logic rnd_ready = 1'b1;
  logic rnd_en    = 1'b0;
  assign m_axis_tready = rnd_en ? rnd_ready : tb_ready;

  logic [DBITS-1:0] exp_q[$];
  int checks     = 0;
  int failures   = 0;
  int words_seen = 0;
  int seen_snap  = 0;

  logic             prev_stall = 1'b0;
  logic [DBITS-1:0] prev_data  = '0;

  typedef struct {
    logic [6:0]  bin;
    logic [31:0] inc;
    logic        last;
    int          n;
    logic [63:0] w0;
    logic [63:0] w1;
  } vec_t;
  vec_t tbl[14];

  logic        m_open;
  logic [6:0]  m_bin;
  logic [31:0] m_sum;
  logic [6:0]  r_bin;
  logic [31:0] r_inc;
  logic        r_last;

  bin_event_coalescer #(
    .ABITS(ABITS), .DBITS(DBITS), .VBITS(VBITS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_bin         (s_bin),
    .s_inc         (s_inc),
    .s_last        (s_last),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .sat_flag      (sat_flag),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial forever begin
    @(posedge clock);
    #1;
    rnd_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- helpers / drivers ----------------
  function automatic logic [63:0] w(input logic [6:0] b, input logic [31:0] s);
    return {25'd0, b, s};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Returns #1 after the clock edge that accepted the event.
  task automatic send(input logic [6:0] b, input logic [31:0] v, input logic l);
    int n = 0;
    s_axis_tvalid = 1'b1;
    s_bin = b;
    s_inc = v;
    s_last = l;
    @(negedge clock);
    while (!s_axis_tready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL send_stuck: bin %0d tready stayed 0 for %0d cycles, required 1", b, n);
    end
    @(posedge clock);
    #1;
    s_axis_tvalid = 1'b0;
    s_last = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clock) begin
    if (!reset && prev_stall && m_axis_tvalid)
      check("tdata_hold", m_axis_tdata, prev_data);
    if (!reset && m_axis_tvalid && m_axis_tready) begin
      words_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word: got 0x%h expected no word", m_axis_tdata);
      end else begin
        check("word", m_axis_tdata, exp_q.pop_front());
      end
    end
    prev_stall = !reset && m_axis_tvalid && !m_axis_tready;
    prev_data  = m_axis_tdata;
  end

  // ---------------- test sequence ----------------
  initial begin
    tbl[0]  = '{7'd10,  32'd1,          1'b0, 0, 64'h0,            64'h0};
    tbl[1]  = '{7'd10,  32'd2,          1'b0, 0, 64'h0,            64'h0};
    tbl[2]  = '{7'd10,  32'd3,          1'b0, 0, 64'h0,            64'h0};
    tbl[3]  = '{7'd11,  32'd0,          1'b0, 0, 64'h0,            64'h0};
    tbl[4]  = '{7'd11,  32'd5,          1'b0, 1, w(7'd10, 32'd6),  64'h0};
    tbl[5]  = '{7'd12,  32'd7,          1'b1, 2, w(7'd11, 32'd5),  w(7'd12, 32'd7)};
    tbl[6]  = '{7'd20,  32'd1,          1'b1, 1, w(7'd20, 32'd1),  64'h0};
    tbl[7]  = '{7'd20,  32'd2,          1'b0, 0, 64'h0,            64'h0};
    tbl[8]  = '{7'd21,  32'd1,          1'b1, 2, w(7'd20, 32'd2),  w(7'd21, 32'd1)};
    tbl[9]  = '{7'd30,  32'd4,          1'b0, 0, 64'h0,            64'h0};
    tbl[10] = '{7'd31,  32'd0,          1'b1, 1, w(7'd30, 32'd4),  64'h0};
    tbl[11] = '{7'd127, 32'h8000_0000,  1'b0, 0, 64'h0,            64'h0};
    tbl[12] = '{7'd127, 32'h7FFF_FFFF,  1'b1, 1, w(7'd127, 32'hFFFF_FFFF), 64'h0};
    tbl[13] = '{7'd0,   32'd0,          1'b1, 0, 64'h0,            64'h0};

    // Reset values
    step(3);
    reset = 1'b0;
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_tdata", m_axis_tdata, 64'd0);
    check("rst_sat", 64'(sat_flag), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(EMPTY));
    step(1);
    check("rst_tready", 64'(s_axis_tready), 64'd1);

    // Run merge, then idle flush of the trailing run
    exp_q.push_back(w(7'd5, 32'd7));
    exp_q.push_back(w(7'd9, 32'd1));
    send(7'd5, 32'd3, 1'b0);
    send(7'd5, 32'd4, 1'b0);
    send(7'd9, 32'd1, 1'b0);
    check("merge_valid", 64'(m_axis_tvalid), 64'd1);
    check("merge_data", m_axis_tdata, w(7'd5, 32'd7));
    step(15);
    check("merge_to_early", 64'(m_axis_tvalid), 64'd0);
    step(1);
    check("merge_to_valid", 64'(m_axis_tvalid), 64'd1);
    check("merge_to_data", m_axis_tdata, w(7'd9, 32'd1));
    step(2);

    // Exact timeout latency for a lone event
    exp_q.push_back(w(7'd2, 32'd10));
    send(7'd2, 32'd10, 1'b0);
    step(15);
    check("to_early", 64'(m_axis_tvalid), 64'd0);
    step(1);
    check("to_valid", 64'(m_axis_tvalid), 64'd1);
    check("to_data", m_axis_tdata, w(7'd2, 32'h0000_000A));
    step(2);

    // Table-driven runs
    for (int i = 0; i < 14; i++) begin
      if (tbl[i].n >= 1) exp_q.push_back(tbl[i].w0);
      if (tbl[i].n >= 2) exp_q.push_back(tbl[i].w1);
      send(tbl[i].bin, tbl[i].inc, tbl[i].last);
    end
    step(25);
    check("tbl_drained", 64'(exp_q.size()), 64'd0);
    check("tbl_no_sat", 64'(sat_flag), 64'd0);
    check("tbl_state", 64'(dbg_state), 64'(EMPTY));

    // Backpressure
    tb_ready = 1'b0;
    exp_q.push_back(w(7'd1, 32'd1));
    exp_q.push_back(w(7'd2, 32'd1));
    exp_q.push_back(w(7'd3, 32'd1));
    send(7'd1, 32'd1, 1'b0);
    send(7'd2, 32'd1, 1'b0);
    check("bp_tready", 64'(s_axis_tready), 64'd0);
    check("bp_valid", 64'(m_axis_tvalid), 64'd1);
    check("bp_data", m_axis_tdata, w(7'd1, 32'd1));
    fork
      send(7'd3, 32'd1, 1'b0);
      begin
        step(3);
        check("bp_hold", m_axis_tdata, w(7'd1, 32'd1));
        tb_ready = 1'b1;
      end
    join
    step(25);
    check("bp_drained", 64'(exp_q.size()), 64'd0);

    // Saturation
    exp_q.push_back(w(7'd7, 32'hFFFF_FFFF));
    send(7'd7, 32'hFFFF_FFF0, 1'b0);
    check("sat_before", 64'(sat_flag), 64'd0);
    send(7'd7, 32'h0000_0020, 1'b1);
    check("sat_set", 64'(sat_flag), 64'd1);
    step(1);
    check("sat_valid", 64'(m_axis_tvalid), 64'd1);
    check("sat_data", m_axis_tdata, w(7'd7, 32'hFFFF_FFFF));
    step(20);
    check("sat_sticky", 64'(sat_flag), 64'd1);

    // Zero increment alone, then s_last latency
    send(7'd4, 32'd0, 1'b0);
    step(3);
    check("zero_state", 64'(dbg_state), 64'(EMPTY));
    check("zero_novalid", 64'(m_axis_tvalid), 64'd0);
    exp_q.push_back(w(7'd0, 32'd5));
    send(7'd0, 32'd5, 1'b1);
    check("last_early", 64'(m_axis_tvalid), 64'd0);
    step(1);
    check("last_valid", 64'(m_axis_tvalid), 64'd1);
    check("last_data", m_axis_tdata, w(7'd0, 32'd5));
    step(3);

    // Random stream against a run model, with random downstream stalls
    rnd_en = 1'b1;
    m_open = 1'b0;
    m_bin  = '0;
    m_sum  = '0;
    for (int i = 0; i < 80; i++) begin
      r_bin  = 7'($urandom_range(0, 3));
      r_inc  = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 1000));
      r_last = ($urandom_range(0, 9) == 0);
      if (r_inc != 32'd0) begin
        if (!m_open) begin
          m_open = 1'b1;
          m_bin  = r_bin;
          m_sum  = r_inc;
        end else if (r_bin == m_bin) begin
          m_sum = m_sum + r_inc;
        end else begin
          exp_q.push_back(w(m_bin, m_sum));
          m_bin = r_bin;
          m_sum = r_inc;
        end
      end
      if (r_last && m_open) begin
        exp_q.push_back(w(m_bin, m_sum));
        m_open = 1'b0;
      end
      send(r_bin, r_inc, r_last);
    end
    if (m_open) exp_q.push_back(w(m_bin, m_sum));
    rnd_en   = 1'b0;
    tb_ready = 1'b1;
    step(40);
    check("rnd_drained", 64'(exp_q.size()), 64'd0);

    // Reset mid-run: word for bin 1 pending, bin 3 accumulating
    tb_ready = 1'b0;
    send(7'd1, 32'd1, 1'b0);
    send(7'd3, 32'd1, 1'b0);
    check("mid_valid", 64'(m_axis_tvalid), 64'd1);
    seen_snap = words_seen;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("mid_rst_valid", 64'(m_axis_tvalid), 64'd0);
    check("mid_rst_state", 64'(dbg_state), 64'(EMPTY));
    check("mid_rst_sat", 64'(sat_flag), 64'd0);
    tb_ready = 1'b1;
    step(30);
    check("mid_no_words", 64'(words_seen), 64'(seen_snap));
    check("final_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
